// File: rtl/fitbit_pkg.sv
// Shared definitions for the activity display path: metric encodings,
// display limits and the decimal-point pattern for each metric.
package fitbit_pkg;

    localparam int          BIN_W    = 14;
    localparam int          BCD_MAX  = 9999;
    localparam logic [3:0]  DP_DIST  = 4'b0010;

    typedef enum logic [1:0] {
        MODE_STEPS  = 2'd0,
        MODE_DIST   = 2'd1,
        MODE_OVER32 = 2'd2,
        MODE_HIACT  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_SAMPLE  = 2'd0,
        ST_CONVERT = 2'd1,
        ST_HOLD    = 2'd2
    } sched_state_t;

    // Distance is shown as ddd.d, so only digit 1 carries a decimal point.
    function automatic logic [3:0] dp_for_mode(input mode_t m);
        return (m == MODE_DIST) ? DP_DIST : 4'b0000;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: loads on start, performs one
// shift/add-3 step per clock for BIN_W clocks, then pulses done.
module bin2bcd_serial #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [15:0]      bcd,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [15:0]      adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                shreg <= bin;
                bcd   <= '0;
                cnt   <= CW'(BIN_W);
                busy  <= 1'b1;
            end else if (busy) begin
                bcd   <= {adj[14:0], shreg[BIN_W-1]};
                shreg <= {shreg[BIN_W-2:0], 1'b0};
                cnt   <= cnt - 1'b1;
                // Final bit shifted this edge: result and done appear together.
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/display_mode_scheduler.sv
// Rotates four activity metrics onto the 4-digit display once per dwell
// period, clamping each to 9999 and converting it to BCD serially.
//
// state      | meaning
// SAMPLE     | select metric by mode, clamp, start the converter
// CONVERT    | wait for converter done, then update all outputs at once
// HOLD       | wait for a (possibly pending) second tick, advance dwell/mode
module display_mode_scheduler
    import fitbit_pkg::*;
#(
    parameter int DWELL_SEC = 2,
    parameter int BIN_W     = fitbit_pkg::BIN_W
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SEC_TICK,
    input  logic        PAUSE,
    input  logic [22:0] step_count,
    input  logic [13:0] mile_tenths,
    input  logic [13:0] over32_secs,
    input  logic [15:0] hiact_secs,
    output logic [15:0] bcd_digits,
    output logic [3:0]  dp_mask,
    output logic [1:0]  mode,
    output logic        bcd_valid,
    output logic        sat
);

    sched_state_t     state;
    mode_t            mode_r;
    logic [3:0]       dwell;
    logic             pend_tick;
    logic             sat_s;
    logic [3:0]       dp_s;

    logic [22:0]      sel;
    logic             sat_next;
    logic [BIN_W-1:0] conv_val;
    logic             conv_start;
    logic             conv_busy;
    logic             conv_done;
    logic [15:0]      conv_bcd;

    // Compare at full input width so large values clamp instead of wrapping.
    always_comb begin
        sel = '0;
        case (mode_r)
            MODE_STEPS:  sel = step_count;
            MODE_DIST:   sel = {9'd0, mile_tenths};
            MODE_OVER32: sel = {9'd0, over32_secs};
            MODE_HIACT:  sel = {7'd0, hiact_secs};
            default:     sel = '0;
        endcase
        sat_next = (sel > 23'(BCD_MAX));
        conv_val = sat_next ? BIN_W'(BCD_MAX) : sel[BIN_W-1:0];
    end

    assign conv_start = (state == ST_SAMPLE) && !conv_busy;

    bin2bcd_serial #(.BIN_W(BIN_W)) u_bin2bcd (
        .clk   (CLK),
        .rst_n (RESET),
        .start (conv_start),
        .bin   (conv_val),
        .bcd   (conv_bcd),
        .busy  (conv_busy),
        .done  (conv_done)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= ST_SAMPLE;
            mode_r     <= MODE_STEPS;
            dwell      <= '0;
            pend_tick  <= 1'b0;
            sat_s      <= 1'b0;
            dp_s       <= '0;
            bcd_digits <= '0;
            dp_mask    <= '0;
            bcd_valid  <= 1'b0;
            sat        <= 1'b0;
        end else begin
            case (state)
                ST_SAMPLE: begin
                    sat_s <= sat_next;
                    dp_s  <= dp_for_mode(mode_r);
                    if (SEC_TICK)
                        pend_tick <= 1'b1;
                    state <= ST_CONVERT;
                end
                ST_CONVERT: begin
                    if (SEC_TICK)
                        pend_tick <= 1'b1;
                    if (conv_done) begin
                        bcd_digits <= conv_bcd;
                        sat        <= sat_s;
                        dp_mask    <= dp_s;
                        bcd_valid  <= 1'b1;
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (SEC_TICK || pend_tick) begin
                        pend_tick <= 1'b0;
                        if (!PAUSE) begin
                            if (dwell == 4'(DWELL_SEC - 1)) begin
                                dwell  <= '0;
                                mode_r <= mode_t'(mode_r + 2'd1);
                            end else begin
                                dwell <= dwell + 4'd1;
                            end
                        end
                        state <= ST_SAMPLE;
                    end
                end
                default: state <= ST_SAMPLE;
            endcase
        end
    end

    assign mode = mode_r;

endmodule

// File: tb/tb_display_mode_scheduler.sv
// Scoreboard bench for display_mode_scheduler: a metric/dwell model predicts
// each display update when a tick is driven; predictions are popped on update.
module tb_display_mode_scheduler;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        SEC_TICK;
    logic        PAUSE;
    logic [22:0] step_count;
    logic [13:0] mile_tenths;
    logic [13:0] over32_secs;
    logic [15:0] hiact_secs;
    logic [15:0] bcd_digits;
    logic [3:0]  dp_mask;
    logic [1:0]  mode;
    logic        bcd_valid;
    logic        sat;

    display_mode_scheduler #(.DWELL_SEC(2), .BIN_W(14)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SEC_TICK    (SEC_TICK),
        .PAUSE       (PAUSE),
        .step_count  (step_count),
        .mile_tenths (mile_tenths),
        .over32_secs (over32_secs),
        .hiact_secs  (hiact_secs),
        .bcd_digits  (bcd_digits),
        .dp_mask     (dp_mask),
        .mode        (mode),
        .bcd_valid   (bcd_valid),
        .sat         (sat)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [1:0]  mode;
        logic        sat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          m_mode = 0;
    int          m_dwell = 0;
    logic [15:0] shown = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic exp_t predict();
        exp_t e;
        int   raw;
        case (m_mode)
            0:       raw = int'(step_count);
            1:       raw = int'(mile_tenths);
            2:       raw = int'(over32_secs);
            default: raw = int'(hiact_secs);
        endcase
        e.sat = (raw > 9999);
        if (e.sat)
            raw = 9999;
        e.digits = {4'(raw / 1000), 4'((raw / 100) % 10), 4'((raw / 10) % 10), 4'(raw % 10)};
        e.dp     = (m_mode == 1) ? 4'b0010 : 4'b0000;
        e.mode   = 2'(m_mode);
        return e;
    endfunction

    task automatic model_tick();
        if (!PAUSE) begin
            m_dwell++;
            if (m_dwell == 2) begin
                m_dwell = 0;
                m_mode  = (m_mode + 1) % 4;
            end
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got digits %0h", tag, bcd_digits);
            return;
        end
        e = sb.pop_front();
        check({tag, "_digits"}, 32'(bcd_digits), 32'(e.digits));
        check({tag, "_dp"},     32'(dp_mask),    32'(e.dp));
        check({tag, "_mode"},   32'(mode),       32'(e.mode));
        check({tag, "_sat"},    32'(sat),        32'(e.sat));
        check({tag, "_valid"},  32'(bcd_valid),  32'd1);
        shown = e.digits;
    endtask

    // Tick serviced at edge T; the refreshed value must appear exactly at T+16.
    task automatic tick_and_check(input string tag, input int mid_over32);
        SEC_TICK = 1'b1;
        wait_edges(1);
        SEC_TICK = 1'b0;
        model_tick();
        sb.push_back(predict());
        check({tag, "_mode_now"}, 32'(mode), 32'(m_mode));
        wait_edges(5);
        if (mid_over32 >= 0)
            over32_secs = 14'(mid_over32);
        wait_edges(10);
        check({tag, "_pre"}, 32'(bcd_digits), 32'(shown));
        wait_edges(1);
        compare_out(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, 32'(bcd_digits), 32'd0);
        check({tag, "_dp"},     32'(dp_mask),    32'd0);
        check({tag, "_mode"},   32'(mode),       32'd0);
        check({tag, "_valid"},  32'(bcd_valid),  32'd0);
        check({tag, "_sat"},    32'(sat),        32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RESET       = 1'b0;
        SEC_TICK    = 1'b0;
        PAUSE       = 1'b0;
        step_count  = 23'd1234;
        mile_tenths = 14'd25;
        over32_secs = 14'd777;
        hiact_secs  = 16'd4321;

        // Reset and first conversion
        wait_edges(3);
        check_reset_outputs("reset");
        RESET = 1'b1;
        wait_edges(14);
        check("reset_early_valid", 32'(bcd_valid), 32'd0);
        wait_edges(2);
        sb.push_back(predict());
        compare_out("reset_release");

        // Rotation across all four metrics
        for (int i = 0; i < 8; i++) begin
            tick_and_check("rot", -1);
            wait_edges(83);
        end
        check("rot_wrap_mode", 32'(mode), 32'd0);

        // Saturation and boundary values
        step_count = 23'd12345;
        tick_and_check("sat_steps", -1);
        wait_edges(83);
        mile_tenths = 14'd25;
        tick_and_check("dist_25", -1);
        wait_edges(83);
        mile_tenths = 14'd9999;
        tick_and_check("dist_9999", -1);
        wait_edges(83);
        over32_secs = 14'd10000;
        tick_and_check("over32_10000", -1);
        wait_edges(83);

        // Pause in mode 2 with a changing value
        PAUSE = 1'b1;
        for (int i = 0; i < 6; i++) begin
            over32_secs = (i == 3) ? 14'd12000 : 14'(100 * i + 7);
            tick_and_check("pause", (i == 1) ? 5555 : -1);
            wait_edges(83);
        end
        PAUSE = 1'b0;
        over32_secs = 14'd42;
        tick_and_check("unpause1", -1);
        wait_edges(83);
        tick_and_check("unpause2", -1);
        wait_edges(83);

        // Ticks during conversion: one pending, extra dropped
        hiact_secs = 16'd17618;
        step_count = 23'd8;
        SEC_TICK = 1'b1;
        wait_edges(1);
        SEC_TICK = 1'b0;
        model_tick();
        sb.push_back(predict());
        check("conv_tick_mode", 32'(mode), 32'(m_mode));
        wait_edges(4);
        SEC_TICK = 1'b1;
        wait_edges(1);
        SEC_TICK = 1'b0;
        wait_edges(1);
        SEC_TICK = 1'b1;
        wait_edges(1);
        SEC_TICK = 1'b0;
        wait_edges(9);
        compare_out("conv_first");
        model_tick();
        sb.push_back(predict());
        wait_edges(1);
        check("conv_pend_mode", 32'(mode), 32'(m_mode));
        wait_edges(16);
        compare_out("conv_second");
        wait_edges(83);
        tick_and_check("drop_check", -1);
        wait_edges(83);

        // Reset during conversion
        SEC_TICK = 1'b1;
        wait_edges(1);
        SEC_TICK = 1'b0;
        wait_edges(8);
        RESET = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        m_mode  = 0;
        m_dwell = 0;
        sb.delete();
        step_count = 23'h404D2;
        wait_edges(2);
        RESET = 1'b1;
        wait_edges(16);
        sb.push_back(predict());
        compare_out("post_reset");
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
